// File: rtl/ext_pkg.sv
// Shared types and helpers for the immediate-extension unit.
package ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'b00,
        MODE_SIGN   = 2'b01,
        MODE_PREFIX = 2'b10,
        MODE_HIGH   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PREFIXED = 1'b1
    } state_e;

    // Number of result bits the instruction field does not cover.
    function automatic int ext_dif(input int datasize, input int operandsize);
        return datasize - operandsize;
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational widening of an immediate field, optionally completed by a
// previously captured prefix.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATASIZE    = 16,
    parameter int OPERANDSIZE = 11
) (
    input  logic [OPERANDSIZE-1:0]                        operand_i,
    input  logic [ext_dif(DATASIZE, OPERANDSIZE)-1:0]     prefix_i,
    input  logic                                          prefixed_i,
    input  mode_e                                         mode_i,
    output logic [DATASIZE-1:0]                           result_o
);

    localparam int DIF = ext_dif(DATASIZE, OPERANDSIZE);

    // A pending prefix replaces the zero/sign fill; HIGH puts it below the field.
    always_comb begin
        result_o = '0;
        case (mode_i)
            MODE_ZERO: result_o = prefixed_i ? {prefix_i, operand_i}
                                             : {{DIF{1'b0}}, operand_i};
            MODE_SIGN: result_o = prefixed_i ? {prefix_i, operand_i}
                                             : {{DIF{operand_i[OPERANDSIZE-1]}}, operand_i};
            MODE_HIGH: result_o = prefixed_i ? {operand_i, prefix_i}
                                             : {operand_i, {DIF{1'b0}}};
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext.sv
// Registered immediate extender with prefix capture and valid/ready output.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | no prefix held; prefix_q is zero
//   ST_PREFIXED | prefix_q holds the high/low bits for the next immediate
module imm_ext
    import ext_pkg::*;
#(
    parameter int DATASIZE    = 16,
    parameter int OPERANDSIZE = 11
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [OPERANDSIZE-1:0] operand_i,
    input  logic [1:0]             mode_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATASIZE-1:0]    dataext_o,
    output logic                   prefix_ovr_o
);

    localparam int DIF = ext_dif(DATASIZE, OPERANDSIZE);

    if (DIF < 1 || DIF > OPERANDSIZE) begin : g_bad_width
        $error("imm_ext: DATASIZE-OPERANDSIZE must lie in 1..OPERANDSIZE");
    end

    state_e                state_q, state_d;
    logic [DIF-1:0]        prefix_q, prefix_d;
    logic                  valid_q, valid_d;
    logic [DATASIZE-1:0]   data_q, data_d;
    logic                  ovr_q, ovr_d;
    logic                  accept;
    mode_e                 mode;
    logic [DATASIZE-1:0]   result;

    assign mode    = mode_e'(mode_i);
    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o && !flush_i;

    ext_core #(
        .DATASIZE    (DATASIZE),
        .OPERANDSIZE (OPERANDSIZE)
    ) u_core (
        .operand_i  (operand_i),
        .prefix_i   (prefix_q),
        .prefixed_i (state_q == ST_PREFIXED),
        .mode_i     (mode),
        .result_o   (result)
    );

    // Next state: flush wins; otherwise drain, then let an accepted beat load.
    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ovr_d    = 1'b0;
        if (flush_i) begin
            state_d  = ST_IDLE;
            prefix_d = '0;
            valid_d  = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (accept) begin
                if (mode == MODE_PREFIX) begin
                    prefix_d = operand_i[DIF-1:0];
                    state_d  = ST_PREFIXED;
                    ovr_d    = (state_q == ST_PREFIXED);
                end else begin
                    data_d   = result;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                    prefix_d = '0;
                end
            end
        end
    end

    // State, prefix and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            prefix_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
        end
    end

    assign valid_o      = valid_q;
    assign dataext_o    = data_q;
    assign prefix_ovr_o = ovr_q;

endmodule

// File: tb/tb_imm_ext.sv
module tb_imm_ext;

    localparam int DS = 16;
    localparam int OS = 11;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          valid_i;
    logic          ready_o;
    logic [OS-1:0] operand_i;
    logic [1:0]    mode_i;
    logic          flush_i;
    logic          valid_o;
    logic          ready_i;
    logic [DS-1:0] dataext_o;
    logic          prefix_ovr_o;

    int tests  = 0;
    int failed = 0;

    // behavioural model state
    bit        m_valid;
    bit [15:0] m_data;
    bit        m_ovr;
    bit        m_has_pre;
    int        m_pre;
    bit        m_acc;
    int        m_op;
    int        m_r;

    imm_ext #(.DATASIZE(DS), .OPERANDSIZE(OS)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .operand_i    (operand_i),
        .mode_i       (mode_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .dataext_o    (dataext_o),
        .prefix_ovr_o (prefix_ovr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: result = field value placed arithmetically per mode
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_valid = 0; m_data = 0; m_ovr = 0; m_has_pre = 0; m_pre = 0;
        end else begin
            m_acc = valid_i && (!m_valid || ready_i) && !flush_i;
            m_op  = int'(operand_i);
            m_ovr = 0;
            if (flush_i) begin
                m_valid = 0; m_has_pre = 0; m_pre = 0;
            end else if (m_acc && mode_i == 2'd2) begin
                m_ovr     = m_has_pre;
                m_has_pre = 1;
                m_pre     = m_op % 32;
                if (ready_i) m_valid = 0;
            end else if (m_acc) begin
                case (mode_i)
                    2'd0:    m_r = m_has_pre ? m_pre * 2048 + m_op : m_op;
                    2'd1:    m_r = m_has_pre ? m_pre * 2048 + m_op
                                             : (m_op >= 1024 ? m_op + 65536 - 2048 : m_op);
                    default: m_r = m_has_pre ? m_op * 32 + m_pre : m_op * 32;
                endcase
                m_data    = m_r[15:0];
                m_valid   = 1;
                m_has_pre = 0;
                m_pre     = 0;
            end else if (ready_i) begin
                m_valid = 0;
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk_i) begin
        chk("valid_o", {15'd0, valid_o}, {15'd0, m_valid});
        chk("dataext_o", dataext_o, m_data);
        chk("prefix_ovr_o", {15'd0, prefix_ovr_o}, {15'd0, m_ovr});
        chk("ready_o", {15'd0, ready_o}, {15'd0, (!m_valid || ready_i)});
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [10:0] op,
                         input logic rdy, input logic fl);
        valid_i = v; mode_i = m; operand_i = op; ready_i = rdy; flush_i = fl;
        @(negedge clk_i);
        #1;
    endtask

    task automatic expect_res(input string name, input logic [15:0] exp);
        chk({name, " valid"}, {15'd0, valid_o}, 16'd1);
        chk({name, " data"}, dataext_o, exp);
    endtask

    initial begin
        rstn_i = 0; valid_i = 0; mode_i = 0; operand_i = 0; ready_i = 0; flush_i = 0;
        @(negedge clk_i);
        #1;
        chk("rst valid_o", {15'd0, valid_o}, 16'd0);
        chk("rst dataext_o", dataext_o, 16'h0000);
        chk("rst prefix_ovr_o", {15'd0, prefix_ovr_o}, 16'd0);
        chk("rst ready_o", {15'd0, ready_o}, 16'd1);
        rstn_i = 1;

        // basic modes
        drive(1, 2'd0, 11'h7FF, 1, 0); expect_res("zero 7FF", 16'h07FF);
        drive(1, 2'd1, 11'h400, 1, 0); expect_res("sign 400", 16'hFC00);
        drive(1, 2'd1, 11'h3FF, 1, 0); expect_res("sign 3FF", 16'h03FF);
        drive(1, 2'd3, 11'h001, 1, 0); expect_res("high 001", 16'h0020);
        drive(0, 2'd0, 11'h000, 1, 0);
        chk("drain valid", {15'd0, valid_o}, 16'd0);

        // prefix usage
        drive(1, 2'd2, 11'h015, 1, 0);
        chk("prefix no output", {15'd0, valid_o}, 16'd0);
        drive(1, 2'd0, 11'h123, 1, 0); expect_res("pre+zero", 16'hA923);
        drive(1, 2'd2, 11'h015, 1, 0);
        drive(1, 2'd3, 11'h001, 1, 0); expect_res("pre+high", 16'h0035);
        drive(1, 2'd0, 11'h123, 1, 0); expect_res("pre consumed", 16'h0123);

        // prefix overwrite
        drive(1, 2'd2, 11'h001, 1, 0);
        chk("ovr quiet", {15'd0, prefix_ovr_o}, 16'd0);
        drive(1, 2'd2, 11'h01F, 1, 0);
        chk("ovr pulse", {15'd0, prefix_ovr_o}, 16'd1);
        drive(1, 2'd0, 11'h000, 1, 0); expect_res("ovr prefix used", 16'hF800);
        chk("ovr one cycle", {15'd0, prefix_ovr_o}, 16'd0);

        // backpressure
        drive(1, 2'd0, 11'h055, 1, 0); expect_res("bp load", 16'h0055);
        drive(1, 2'd1, 11'h400, 0, 0);
        drive(1, 2'd1, 11'h400, 0, 0);
        chk("bp ready_o", {15'd0, ready_o}, 16'd0);
        expect_res("bp hold", 16'h0055);
        drive(1, 2'd2, 11'h00A, 1, 0);
        chk("bp drained", {15'd0, valid_o}, 16'd0);
        drive(0, 2'd0, 11'h000, 0, 0);
        drive(1, 2'd3, 11'h002, 0, 0); expect_res("bp prefix kept", 16'h004A);
        drive(1, 2'd0, 11'h7FF, 0, 0); expect_res("bp stall", 16'h004A);
        drive(1, 2'd0, 11'h7FF, 1, 0); expect_res("bp release", 16'h07FF);
        drive(0, 2'd0, 11'h000, 1, 0);

        // flush
        drive(1, 2'd0, 11'h001, 0, 0); expect_res("fl load", 16'h0001);
        drive(1, 2'd0, 11'h7FF, 0, 1);
        chk("fl valid dropped", {15'd0, valid_o}, 16'd0);
        chk("fl data kept", dataext_o, 16'h0001);
        drive(1, 2'd2, 11'h015, 1, 0);
        drive(0, 2'd0, 11'h000, 1, 1);
        drive(1, 2'd0, 11'h123, 1, 0); expect_res("fl prefix gone", 16'h0123);

        // async reset mid-stream
        drive(1, 2'd0, 11'h3AA, 1, 0); expect_res("pre-rst", 16'h03AA);
        drive(1, 2'd2, 11'h01F, 1, 0);
        drive(1, 2'd2, 11'h01F, 1, 0);
        chk("pre-rst ovr", {15'd0, prefix_ovr_o}, 16'd1);
        drive(1, 2'd0, 11'h3AA, 0, 0);
        drive(1, 2'd2, 11'h015, 0, 0);
        valid_i = 0;
        #1 rstn_i = 0;
        #1;
        chk("async valid_o", {15'd0, valid_o}, 16'd0);
        chk("async dataext_o", dataext_o, 16'h0000);
        chk("async prefix_ovr_o", {15'd0, prefix_ovr_o}, 16'd0);
        chk("async ready_o", {15'd0, ready_o}, 16'd1);
        @(negedge clk_i);
        #1 rstn_i = 1;

        // streaming after reset
        drive(1, 2'd0, 11'h123, 1, 0); expect_res("st0 no prefix", 16'h0123);
        drive(1, 2'd1, 11'h7FF, 1, 0); expect_res("st1", 16'hFFFF);
        drive(1, 2'd3, 11'h7FF, 1, 0); expect_res("st2", 16'hFFE0);
        drive(1, 2'd0, 11'h000, 1, 0); expect_res("st3", 16'h0000);
        drive(0, 2'd0, 11'h000, 1, 0);
        chk("st end", {15'd0, valid_o}, 16'd0);
        drive(0, 2'd0, 11'h000, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
